// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-port memory arbiter:
// FSM state codes, owner IDs and burst default.
package mem_arb_pkg;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] CORE_OWN = 2'd1;
  localparam logic [1:0] DMA_OWN  = 2'd2;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_DMA  = 1'b1;

  localparam int MAX_BURST_DEF = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Core, DMA and memory bus bundle around the arbiter.
// master = requesters plus memory, slave = arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_rvld;
  logic              dma_req;
  logic              dma_we;
  logic              dma_last;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvld;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic [15:0]       conflict_cnt;

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output dma_req, dma_we, dma_last, dma_addr, dma_wdata,
    output mem_rdata,
    input  core_gnt, core_rvld, dma_gnt, dma_rvld, rdata,
    input  mem_addr, mem_wdata, mem_we, conflict_cnt
  );

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  dma_req, dma_we, dma_last, dma_addr, dma_wdata,
    input  mem_rdata,
    output core_gnt, core_rvld, dma_gnt, dma_rvld, rdata,
    output mem_addr, mem_wdata, mem_we, conflict_cnt
  );
endinterface

// File: rtl/mem_arbiter.sv
// Core/DMA single-port memory arbiter: ownership FSM with
// burst limit, address mux, read-valid return, conflict count.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvld,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_last,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvld,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       conflict_cnt
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);

  logic [1:0]        state_q, state_d;
  logic              last_q, last_d;
  logic [BW-1:0]     beat_q, beat_d, beat_now;
  logic [15:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              crv_q, drv_q;

  logic core_own, dma_own;
  logic owner_req, other_req, owner_gnt, owner_we;
  logic denied, done;

  assign core_own  = state_q == CORE_OWN;
  assign dma_own   = state_q == DMA_OWN;
  assign core_gnt  = core_own & core_req;
  assign dma_gnt   = dma_own & dma_req;
  assign owner_req = core_own ? core_req : dma_req;
  assign other_req = core_own ? dma_req : core_req;
  assign owner_we  = core_own ? core_we : dma_we;
  assign owner_gnt = core_gnt | dma_gnt;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    case (state_q)
      CORE_OWN: begin
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
        mem_we    = core_we & core_gnt;
      end
      DMA_OWN: begin
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        mem_we    = dma_we & dma_gnt;
      end
      default: ;
    endcase
  end

  // beat_now includes the beat granted this cycle
  assign beat_now = (beat_q == BMAX) ? BMAX
                  : beat_q + BW'(owner_gnt);
  assign done = ~owner_req
              | (dma_gnt & dma_last)
              | ((beat_now == BMAX) & other_req);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        beat_d = '0;
        if (core_req && (!dma_req || last_q == OWN_DMA)) begin
          state_d = CORE_OWN;
          last_d  = OWN_CORE;
        end else if (dma_req) begin
          state_d = DMA_OWN;
          last_d  = OWN_DMA;
        end
      end
      CORE_OWN, DMA_OWN: begin
        if (!done) begin
          beat_d = beat_now;
        end else begin
          beat_d = '0;
          if (other_req) begin
            state_d = core_own ? DMA_OWN : CORE_OWN;
            last_d  = core_own ? OWN_DMA : OWN_CORE;
          end else if (!owner_req) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign denied = (core_req & ~core_gnt)
                | (dma_req & ~dma_gnt);
  assign cnt_d  = (denied && cnt_q != 16'hFFFF)
                ? cnt_q + 16'd1 : cnt_q;
  assign rdata_d = (owner_gnt & ~owner_we)
                 ? mem_rdata : rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= OWN_DMA;
      beat_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      crv_q   <= 1'b0;
      drv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      crv_q   <= core_gnt & ~core_we;
      drv_q   <= dma_gnt & ~dma_we;
    end
  end

  assign core_rvld    = crv_q;
  assign dma_rvld     = drv_q;
  assign rdata        = rdata_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded random and directed test of mem_arbiter
// against an ownership-level reference model.
module tb_mem_arbiter;

  localparam int MAXB = 4;

  typedef struct packed {
    logic        cg;
    logic        dg;
    logic        we;
    logic [9:0]  addr;
    logic [15:0] wd;
    logic        crv;
    logic        drv;
    logic [15:0] rd;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(10), .DATA_W(16)) bus ();

  mem_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .core_req     (bus.core_req),
    .core_we      (bus.core_we),
    .core_addr    (bus.core_addr),
    .core_wdata   (bus.core_wdata),
    .core_gnt     (bus.core_gnt),
    .core_rvld    (bus.core_rvld),
    .dma_req      (bus.dma_req),
    .dma_we       (bus.dma_we),
    .dma_last     (bus.dma_last),
    .dma_addr     (bus.dma_addr),
    .dma_wdata    (bus.dma_wdata),
    .dma_gnt      (bus.dma_gnt),
    .dma_rvld     (bus.dma_rvld),
    .rdata        (bus.rdata),
    .mem_addr     (bus.mem_addr),
    .mem_wdata    (bus.mem_wdata),
    .mem_we       (bus.mem_we),
    .mem_rdata    (bus.mem_rdata),
    .conflict_cnt (bus.conflict_cnt)
  );

  logic [15:0] mem [1024];
  logic [15:0] model_mem [1024];
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk)
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // reference model: who owns the bus and what it owes
  int m_own, m_last, m_beats;
  int m_cnt;
  bit m_crv, m_drv;
  logic [15:0] m_rd;

  task automatic model_reset();
    m_own = 0; m_last = 2; m_beats = 0; m_cnt = 0;
    m_crv = 0; m_drv = 0; m_rd = '0;
  endtask

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               n, act, expv, $time);
    end
  endtask

  task automatic cyc(input bit r,
    input bit cr, input bit cw,
    input logic [9:0] ca, input logic [15:0] cd,
    input bit dr, input bit dw, input bit dl,
    input logic [9:0] da, input logic [15:0] dd);
    exp_t e;
    bit gc, gd, oreq, xreq, fin;
    int nb, n;
    @(posedge clk); #1;
    rst = r;
    bus.core_req = cr; bus.core_we = cw;
    bus.core_addr = ca; bus.core_wdata = cd;
    bus.dma_req = dr; bus.dma_we = dw; bus.dma_last = dl;
    bus.dma_addr = da; bus.dma_wdata = dd;
    gc = (m_own == 1) && cr;
    gd = (m_own == 2) && dr;
    e.cg = gc; e.dg = gd;
    e.addr = (m_own == 1) ? ca : (m_own == 2) ? da : 10'd0;
    e.wd = (m_own == 1) ? cd : (m_own == 2) ? dd : 16'd0;
    e.we = (gc && cw) || (gd && dw);
    e.crv = m_crv; e.drv = m_drv;
    e.rd = m_rd; e.cnt = 16'(m_cnt);
    q.push_back(e);
    if (e.we) model_mem[e.addr] = e.wd;
    if (r) begin
      model_reset();
    end else begin
      m_crv = gc && !cw;
      m_drv = gd && !dw;
      if (m_crv) m_rd = model_mem[ca];
      if (m_drv) m_rd = model_mem[da];
      if (((cr && !gc) || (dr && !gd)) && m_cnt < 65535)
        m_cnt++;
      if (m_own == 0) begin
        if (cr && dr) n = (m_last == 2) ? 1 : 2;
        else if (cr) n = 1;
        else if (dr) n = 2;
        else n = 0;
        if (n != 0) begin
          m_own = n; m_last = n; m_beats = 0;
        end
      end else begin
        oreq = (m_own == 1) ? cr : dr;
        xreq = (m_own == 1) ? dr : cr;
        nb = m_beats + ((gc || gd) ? 1 : 0);
        if (nb > MAXB) nb = MAXB;
        fin = !oreq || (gd && dl) || (nb == MAXB && xreq);
        if (!fin) begin
          m_beats = nb;
        end else begin
          m_beats = 0;
          if (xreq) begin
            m_own = 3 - m_own; m_last = m_own;
          end else if (!oreq) begin
            m_own = 0;
          end
        end
      end
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++)
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("core_gnt", 32'(bus.core_gnt), 32'(e.cg));
        chk("dma_gnt", 32'(bus.dma_gnt), 32'(e.dg));
        chk("mem_we", 32'(bus.mem_we), 32'(e.we));
        chk("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
        chk("mem_wdata", 32'(bus.mem_wdata), 32'(e.wd));
        chk("core_rvld", 32'(bus.core_rvld), 32'(e.crv));
        chk("dma_rvld", 32'(bus.dma_rvld), 32'(e.drv));
        chk("rdata", 32'(bus.rdata), 32'(e.rd));
        chk("conflict", 32'(bus.conflict_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin : stim
    bit cr, dr;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 16'(i * 16'h1357) ^ 16'hA5A5;
      model_mem[i] = mem[i];
    end
    mem[5] = 16'hBEEF;
    model_mem[5] = 16'hBEEF;
    rst = 1'b1;
    bus.core_req = 0; bus.core_we = 0;
    bus.core_addr = 0; bus.core_wdata = 0;
    bus.dma_req = 0; bus.dma_we = 0; bus.dma_last = 0;
    bus.dma_addr = 0; bus.dma_wdata = 0;
    model_reset();
    repeat (3) @(posedge clk);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // single core read of 0x005
    cyc(0, 1, 0, 10'h005, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 10'h005, 0, 0, 0, 0, 0, 0);
    idle(3);
    // tie after reset: core first, DMA follows
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      cyc(0, 1, 0, 10'(20 + i), 0, 1, 0, 0, 10'h200, 0);
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 0, 0, 0, 1, 0, 0, 10'(10'h200 + i), 0);
    idle(2);
    // burst limit with both requesting
    for (int i = 0; i < 14; i++)
      cyc(0, i < 10, 1, 10'(40 + i), 16'(i),
          1, 0, 0, 10'(10'h300 + i), 0);
    idle(2);
    // DMA write burst ending on dma_last
    cyc(0, 0, 0, 0, 0, 1, 1, 0, 10'h100, 16'h1111);
    cyc(0, 0, 0, 0, 0, 1, 1, 0, 10'h100, 16'h1111);
    cyc(0, 0, 0, 0, 0, 1, 1, 0, 10'h101, 16'h2222);
    cyc(0, 0, 0, 0, 0, 1, 1, 1, 10'h102, 16'h3333);
    idle(3);
    // reset while a DMA read is granted
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 10'h102, 0);
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 10'h102, 0);
    idle(2);
    // random traffic
    cr = 0; dr = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) cr = !cr;
      if ($urandom_range(0, 3) == 0) dr = !dr;
      cyc($urandom_range(0, 199) == 0,
          cr, 1'($urandom), 10'($urandom), 16'($urandom),
          dr, 1'($urandom), $urandom_range(0, 3) == 0,
          10'($urandom), 16'($urandom));
    end
    idle(2);
    // conflict counter saturation
    for (int i = 0; i < 65540; i++)
      cyc(0, 1, 0, 10'(i), 0, 1, 0, 0, 10'(i + 7), 0);
    idle(3);
    repeat (4) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain act=%0d exp=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
